// File: rtl/memory_arbiter.sv
`default_nettype none
// =============================================================================
// memory_arbiter : round-robin arbiter sharing one memory bus between an
//                  instruction master (m0) and a data master (m1)
// Revision      : 1.0
// =============================================================================

module memory_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         m0_valid,
    input  logic [31:0]  m0_addr,
    input  logic [31:0]  m0_wdata,
    input  logic [3:0]   m0_wstrb,
    output logic         m0_ready,
    output logic [31:0]  m0_rdata,

    input  logic         m1_valid,
    input  logic [31:0]  m1_addr,
    input  logic [31:0]  m1_wdata,
    input  logic [3:0]   m1_wstrb,
    output logic         m1_ready,
    output logic [31:0]  m1_rdata,

    output logic         mem_valid,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic [3:0]   mem_wstrb,
    input  logic [7:0]   enables,
    input  logic [7:0]   slave_ready,
    input  logic [255:0] slave_rdata,
    output logic         bus_error
);

    // Counter value seen during the last ACCESS cycle allowed before timeout
    localparam logic [15:0] c_cnt_last = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_gnt;
    logic        r_last;
    logic [15:0] r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_mem_valid;
    logic        r_m0_ready;
    logic        r_m1_ready;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        r_bus_error;

    logic [2:0]  w_sel;
    logic        w_hit;
    logic        w_sel_ready;
    logic [31:0] w_sel_rdata;
    logic        w_grant_m1;
    logic        w_expired;
    logic        w_done;
    logic        w_fail;
    logic [31:0] w_resp;

    // Lowest-index enable wins when the decoder reports overlapping regions
    always_comb begin
        w_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (enables[i]) begin
                w_sel = 3'(i);
            end
        end
    end

    assign w_hit       = |enables;
    assign w_sel_ready = slave_ready[w_sel];
    assign w_sel_rdata = slave_rdata[{w_sel, 5'd0} +: 32];
    assign w_grant_m1  = m1_valid & (~m0_valid | ~r_last);
    assign w_expired   = (r_cnt == c_cnt_last);
    assign w_done      = ~w_hit | w_sel_ready | w_expired;
    assign w_fail      = ~w_hit | (~w_sel_ready & w_expired);
    assign w_resp      = w_fail ? 32'h0 : w_sel_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_cnt       <= 16'd0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_wstrb     <= 4'h0;
            r_mem_valid <= 1'b0;
            r_m0_ready  <= 1'b0;
            r_m1_ready  <= 1'b0;
            r_m0_rdata  <= 32'h0;
            r_m1_rdata  <= 32'h0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_valid | m1_valid) begin
                        r_state     <= ACCESS;
                        r_mem_valid <= 1'b1;
                        r_gnt       <= w_grant_m1;
                        r_cnt       <= 16'd0;
                        r_addr      <= w_grant_m1 ? m1_addr  : m0_addr;
                        r_wdata     <= w_grant_m1 ? m1_wdata : m0_wdata;
                        r_wstrb     <= w_grant_m1 ? m1_wstrb : m0_wstrb;
                    end
                end

                ACCESS: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_done) begin
                        r_state     <= RESP;
                        r_mem_valid <= 1'b0;
                        r_bus_error <= w_fail;
                        r_m0_ready  <= ~r_gnt;
                        r_m1_ready  <= r_gnt;
                        if (r_gnt) begin
                            r_m1_rdata <= w_resp;
                        end else begin
                            r_m0_rdata <= w_resp;
                        end
                    end
                end

                RESP: begin
                    r_state     <= IDLE;
                    r_m0_ready  <= 1'b0;
                    r_m1_ready  <= 1'b0;
                    r_bus_error <= 1'b0;
                    r_last      <= r_gnt;
                    r_cnt       <= 16'd0;
                end

                default: begin
                    r_state     <= IDLE;
                    r_mem_valid <= 1'b0;
                    r_m0_ready  <= 1'b0;
                    r_m1_ready  <= 1'b0;
                    r_bus_error <= 1'b0;
                    r_cnt       <= 16'd0;
                end
            endcase
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign m0_ready  = r_m0_ready;
    assign m1_ready  = r_m1_ready;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign bus_error = r_bus_error;

endmodule

`default_nettype wire
